// File: rtl/sb_pkg.sv
// Shared definitions for the scoreboard core: request-type encodings and the
// default response-entry layout.
package sb_pkg;

   localparam logic SB_READ  = 1'b0;
   localparam logic SB_WRITE = 1'b1;

   localparam int SB_DEF_WIDTH   = 8;
   localparam int SB_DEF_TXID_SZ = 2;

   typedef struct packed {
      logic [SB_DEF_TXID_SZ-1:0] txid;
      logic [SB_DEF_WIDTH-1:0]   data;
   } sb_resp_t;

endpackage

// File: rtl/sb_resp_fifo.sv
// Two-entry srdy/drdy response buffer. Slot 0 is always the head, so the
// outputs come straight from a register.
module sb_resp_fifo
   import sb_pkg::*;
#(
   parameter type entry_t = sb_resp_t
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_srdy_i,
   output logic       in_drdy_o,
   input  entry_t     in_data_i,
   output logic       out_srdy_o,
   input  logic       out_drdy_i,
   output entry_t     out_data_o,
   output logic [1:0] count_o
);

   entry_t     slot0_q, slot0_d;
   entry_t     slot1_q, slot1_d;
   logic [1:0] count_q, count_d;
   logic       push;
   logic       pop;

   assign in_drdy_o  = (count_q != 2'd2);
   assign out_srdy_o = (count_q != 2'd0);
   assign out_data_o = slot0_q;
   assign count_o    = count_q;

   assign push = in_srdy_i & in_drdy_o;
   assign pop  = out_srdy_o & out_drdy_i;

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            if (push) begin
               slot0_d = in_data_i;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               slot0_d = in_data_i;
            end else if (push) begin
               slot1_d = in_data_i;
               count_d = 2'd2;
            end else if (pop) begin
               count_d = 2'd0;
            end
         end
         default: begin
            // Full: push is blocked by in_drdy, so only a pop can happen.
            if (pop) begin
               slot0_d = slot1_q;
               count_d = 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sb_core.sv
// Scoreboard storage core: masked writes into an item array, tagged in-order
// read responses. Define SB_CORE_MASK_EN to honour c_mask on writes.
module sb_core
   import sb_pkg::*;
#(
   parameter int width   = 8,
   parameter int items   = 64,
   parameter int txid_sz = 2,
   parameter int asz     = $clog2(items)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               c_srdy,
   output logic               c_drdy,
   input  logic               c_req_type,
   input  logic [txid_sz-1:0] c_txid,
   input  logic [width-1:0]   c_mask,
   input  logic [width-1:0]   c_data,
   input  logic [asz-1:0]     c_itemid,
   output logic               p_srdy,
   input  logic               p_drdy,
   output logic [txid_sz-1:0] p_txid,
   output logic [width-1:0]   p_data
);

   typedef struct packed {
      logic [txid_sz-1:0] txid;
      logic [width-1:0]   data;
   } resp_t;

   localparam logic [asz:0] ITEMS_LIM = (asz + 1)'(items);

   logic [width-1:0] mem_q [items];
   logic             req_xfer;
   logic             wr_en;
   logic             rd_en;
   logic             in_range;
   logic [width-1:0] rd_word;
   logic [width-1:0] wr_word;
   logic             fifo_in_drdy;
   logic [1:0]       resp_count_unused;
   resp_t            push_entry;
   resp_t            head_entry;

   assign req_xfer = c_srdy & c_drdy;
   assign wr_en    = req_xfer & (c_req_type == SB_WRITE);
   assign rd_en    = req_xfer & (c_req_type == SB_READ);

   // Extra top bit keeps the range test meaningful for power-of-two sizes.
   assign in_range = ({1'b0, c_itemid} < ITEMS_LIM);
   assign rd_word  = in_range ? mem_q[c_itemid] : '0;

`ifdef SB_CORE_MASK_EN
   assign wr_word = (rd_word & ~c_mask) | (c_data & c_mask);
`else
   logic mask_unused;
   assign mask_unused = ^c_mask;
   assign wr_word     = c_data;
`endif

   generate
      for (genvar gi = 0; gi < items; gi++) begin : g_item
         always_ff @(posedge clk) begin
            if (reset) begin
               mem_q[gi] <= '0;
            end else if (wr_en && (c_itemid == asz'(gi))) begin
               mem_q[gi] <= wr_word;
            end
         end
      end
   endgenerate

   assign push_entry.txid = c_txid;
   assign push_entry.data = rd_word;

   sb_resp_fifo #(
      .entry_t (resp_t)
   ) u_resp_fifo (
      .clk        (clk),
      .reset      (reset),
      .in_srdy_i  (rd_en),
      .in_drdy_o  (fifo_in_drdy),
      .in_data_i  (push_entry),
      .out_srdy_o (p_srdy),
      .out_drdy_i (p_drdy),
      .out_data_o (head_entry),
      .count_o    (resp_count_unused)
   );

   // Writes are held off too when the buffer is full, keeping request order trivial.
   assign c_drdy = ~reset & fifo_in_drdy;
   assign p_txid = head_entry.txid;
   assign p_data = head_entry.data;

endmodule

// File: tb/tb_sb_core.sv
// Self-checking bench for sb_core: directed scenarios plus a randomized run
// against an array-and-queue reference model.
module tb_sb_core;

   logic       clk = 1'b0;
   logic       reset;
   logic       c_srdy;
   logic       c_drdy;
   logic       c_req_type;
   logic [1:0] c_txid;
   logic [7:0] c_mask;
   logic [7:0] c_data;
   logic [5:0] c_itemid;
   logic       p_srdy;
   logic       p_drdy;
   logic [1:0] p_txid;
   logic [7:0] p_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] model [64];
   logic [9:0] exp_q [$];

   bit         s_acc;
   bit         s_pop;
   logic [1:0] s_ptx;
   logic [7:0] s_pd;
   logic [9:0] s_exp;

`ifdef SB_CORE_MASK_EN
   localparam logic [7:0] MASK_EXP = 8'hAF;
`else
   localparam logic [7:0] MASK_EXP = 8'hFF;
`endif

   always #5 clk = ~clk;

   sb_core dut (
      .clk        (clk),
      .reset      (reset),
      .c_srdy     (c_srdy),
      .c_drdy     (c_drdy),
      .c_req_type (c_req_type),
      .c_txid     (c_txid),
      .c_mask     (c_mask),
      .c_data     (c_data),
      .c_itemid   (c_itemid),
      .p_srdy     (p_srdy),
      .p_drdy     (p_drdy),
      .p_txid     (p_txid),
      .p_data     (p_data)
   );

   task set_req(input bit srdy, input bit typ, input logic [1:0] tx,
                input logic [5:0] id, input logic [7:0] m, input logic [7:0] d);
      c_srdy     = srdy;
      c_req_type = typ;
      c_txid     = tx;
      c_itemid   = id;
      c_mask     = m;
      c_data     = d;
   endtask

   // Records what transfers at the coming edge, updates the model, and advances.
   task step();
      s_acc = c_srdy && c_drdy;
      s_pop = p_srdy && p_drdy;
      s_ptx = p_txid;
      s_pd  = p_data;
      s_exp = 'x;
      if (reset) begin
         for (int i = 0; i < 64; i++) model[i] = 8'h00;
         exp_q.delete();
      end else begin
         if (s_pop && exp_q.size() > 0) s_exp = exp_q.pop_front();
         if (s_acc) begin
            if (c_req_type) begin
`ifdef SB_CORE_MASK_EN
               model[c_itemid] = (model[c_itemid] & ~c_mask) | (c_data & c_mask);
`else
               model[c_itemid] = c_data;
`endif
            end else begin
               exp_q.push_back({c_txid, model[c_itemid]});
            end
         end
      end
      @(negedge clk);
   endtask

   task test_reset();
      reset  = 1'b1;
      p_drdy = 1'b0;
      set_req(0, 0, 0, 0, 0, 0);
      repeat (3) step();
      n_checks++; if (c_drdy !== 1'b0) begin n_fail++; $display("FAIL reset_c_drdy: got %b expected 0", c_drdy); end
      n_checks++; if (p_srdy !== 1'b0) begin n_fail++; $display("FAIL reset_p_srdy: got %b expected 0", p_srdy); end
      n_checks++; if ({p_txid, p_data} !== 10'h0) begin n_fail++; $display("FAIL reset_p_out: got %h/%h expected 0/00", p_txid, p_data); end
      reset = 1'b0;
      #1;
      n_checks++; if (c_drdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_c_drdy: got %b expected 1", c_drdy); end
      $display("test_reset: done");
   endtask

   task test_read_latency();
      p_drdy = 1'b0;
      set_req(1, 0, 2'd2, 6'd5, 8'h00, 8'h00);
      step();
      set_req(0, 0, 0, 0, 0, 0);
      n_checks++; if (!s_acc) begin n_fail++; $display("FAIL lat_accept: got 0 expected 1"); end
      n_checks++; if ({p_srdy, p_txid, p_data} !== {1'b1, 2'd2, 8'h00}) begin
         n_fail++; $display("FAIL lat_resp: got srdy=%b txid=%0d data=%h expected srdy=1 txid=2 data=00", p_srdy, p_txid, p_data); end
      p_drdy = 1'b1;
      step();
      n_checks++; if (!s_pop || {s_ptx, s_pd} !== s_exp) begin
         n_fail++; $display("FAIL lat_pop: got pop=%b %h expected pop=1 %h", s_pop, {s_ptx, s_pd}, s_exp); end
      n_checks++; if (p_srdy !== 1'b0) begin n_fail++; $display("FAIL lat_empty: got %b expected 0", p_srdy); end
      $display("test_read_latency: read item5 txid2 -> %h", s_pd);
   endtask

   task test_write_read();
      p_drdy = 1'b1;
      set_req(1, 1, 2'd0, 6'd3, 8'hFF, 8'hA5);
      step();
      set_req(1, 0, 2'd1, 6'd3, 8'h00, 8'h00);
      step();
      set_req(0, 0, 0, 0, 0, 0);
      n_checks++; if ({p_srdy, p_txid, p_data} !== {1'b1, 2'd1, 8'hA5}) begin
         n_fail++; $display("FAIL wr_rd: got srdy=%b txid=%0d data=%h expected srdy=1 txid=1 data=a5", p_srdy, p_txid, p_data); end
      step();
      n_checks++; if (!s_pop || {s_ptx, s_pd} !== s_exp) begin
         n_fail++; $display("FAIL wr_rd_pop: got pop=%b %h expected pop=1 %h", s_pop, {s_ptx, s_pd}, s_exp); end
      $display("test_write_read: item3 -> %h", s_pd);
   endtask

   task test_mask();
      p_drdy = 1'b1;
      set_req(1, 1, 2'd0, 6'd3, 8'h0F, 8'hFF);
      step();
      set_req(1, 0, 2'd3, 6'd3, 8'h00, 8'h00);
      step();
      set_req(0, 0, 0, 0, 0, 0);
      n_checks++; if (p_data !== MASK_EXP) begin
         n_fail++; $display("FAIL mask: got %h expected %h", p_data, MASK_EXP); end
      step();
      n_checks++; if (!s_pop || {s_ptx, s_pd} !== s_exp) begin
         n_fail++; $display("FAIL mask_pop: got pop=%b %h expected pop=1 %h", s_pop, {s_ptx, s_pd}, s_exp); end
      $display("test_mask: item3 -> %h", s_pd);
   endtask

   task test_backpressure();
      int got;
      logic [9:0] held;
      p_drdy = 1'b0;
      set_req(1, 0, 2'd0, 6'd0, 8'h00, 8'h00);
      step();
      n_checks++; if (!s_acc) begin n_fail++; $display("FAIL bp_acc0: got 0 expected 1"); end
      set_req(1, 0, 2'd1, 6'd3, 8'h00, 8'h00);
      step();
      n_checks++; if (!s_acc) begin n_fail++; $display("FAIL bp_acc1: got 0 expected 1"); end
      set_req(1, 0, 2'd2, 6'd5, 8'h00, 8'h00);
      n_checks++; if (c_drdy !== 1'b0) begin n_fail++; $display("FAIL bp_full_drdy: got %b expected 0", c_drdy); end
      held = {p_txid, p_data};
      step();
      n_checks++; if (s_acc) begin n_fail++; $display("FAIL bp_acc2: got 1 expected 0"); end
      n_checks++; if ({p_txid, p_data} !== held) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", {p_txid, p_data}, held); end
      p_drdy = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
         step();
         if (s_acc) c_srdy = 1'b0;
         if (s_pop) begin
            n_checks++; if (s_ptx !== 2'(got) || {s_ptx, s_pd} !== s_exp) begin
               n_fail++; $display("FAIL bp_order: got %h expected txid %0d %h", {s_ptx, s_pd}, got, s_exp); end
            $display("test_backpressure: response txid=%0d data=%h", s_ptx, s_pd);
            got++;
         end
      end
      n_checks++; if (got != 3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", got); end
      set_req(0, 0, 0, 0, 0, 0);
   endtask

   task test_back_to_back();
      int pops;
      int first_pop;
      int last_pop;
      bit all_acc;
      p_drdy    = 1'b1;
      pops      = 0;
      first_pop = -1;
      last_pop  = -1;
      all_acc   = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k < 8) set_req(1, 0, 2'(k), 6'(k), 8'h00, 8'h00);
         else set_req(0, 0, 0, 0, 0, 0);
         step();
         if (k < 8 && !s_acc) all_acc = 1'b0;
         if (s_pop) begin
            n_checks++; if ({s_ptx, s_pd} !== s_exp) begin
               n_fail++; $display("FAIL b2b_data: got %h expected %h", {s_ptx, s_pd}, s_exp); end
            if (first_pop < 0) first_pop = k;
            last_pop = k;
            pops++;
         end
      end
      n_checks++; if (!all_acc) begin n_fail++; $display("FAIL b2b_drdy: got a stalled accept expected none"); end
      n_checks++; if (pops != 8 || first_pop != 1 || last_pop != 8) begin
         n_fail++; $display("FAIL b2b_timing: got pops=%0d first=%0d last=%0d expected 8/1/8", pops, first_pop, last_pop); end
      $display("test_back_to_back: %0d responses on steps %0d..%0d", pops, first_pop, last_pop);
   endtask

   task test_reset_mid();
      p_drdy = 1'b1;
      set_req(1, 1, 2'd0, 6'd3, 8'hFF, 8'hA5);
      step();
      p_drdy = 1'b0;
      set_req(1, 0, 2'd0, 6'd1, 8'h00, 8'h00);
      step();
      set_req(1, 0, 2'd1, 6'd3, 8'h00, 8'h00);
      step();
      set_req(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++; if ({p_srdy, p_txid, p_data} !== 11'h0) begin
         n_fail++; $display("FAIL rst_mid_out: got srdy=%b txid=%0d data=%h expected 0/0/00", p_srdy, p_txid, p_data); end
      set_req(1, 0, 2'd3, 6'd3, 8'h00, 8'h00);
      step();
      set_req(0, 0, 0, 0, 0, 0);
      n_checks++; if ({p_srdy, p_txid, p_data} !== {1'b1, 2'd3, 8'h00}) begin
         n_fail++; $display("FAIL rst_mid_clear: got srdy=%b txid=%0d data=%h expected 1/3/00", p_srdy, p_txid, p_data); end
      p_drdy = 1'b1;
      step();
      $display("test_reset_mid: item3 after reset -> %h", s_pd);
   endtask

   task test_random();
      bit         prev_stall;
      logic [9:0] prev_out;
      prev_stall = 1'b0;
      prev_out   = '0;
      for (int k = 0; k < 400; k++) begin
         set_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom),
                 6'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
         p_drdy = $urandom_range(0, 2) != 0;
         n_checks++; if (c_drdy !== (exp_q.size() < 2)) begin
            n_fail++; $display("FAIL rnd_drdy: got %b expected %b", c_drdy, exp_q.size() < 2); end
         n_checks++; if (p_srdy !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL rnd_srdy: got %b expected %b", p_srdy, exp_q.size() != 0); end
         if (prev_stall) begin
            n_checks++; if ({p_txid, p_data} !== prev_out) begin
               n_fail++; $display("FAIL rnd_hold: got %h expected %h", {p_txid, p_data}, prev_out); end
         end
         prev_stall = p_srdy && !p_drdy;
         prev_out   = {p_txid, p_data};
         step();
         if (s_pop) begin
            n_checks++; if ({s_ptx, s_pd} !== s_exp) begin
               n_fail++; $display("FAIL rnd_resp: got %h expected %h", {s_ptx, s_pd}, s_exp); end
         end
      end
      set_req(0, 0, 0, 0, 0, 0);
      p_drdy = 1'b1;
      for (int k = 0; k < 10 && (p_srdy || exp_q.size() != 0); k++) begin
         step();
         if (s_pop) begin
            n_checks++; if ({s_ptx, s_pd} !== s_exp) begin
               n_fail++; $display("FAIL rnd_drain: got %h expected %h", {s_ptx, s_pd}, s_exp); end
         end
      end
      n_checks++; if (p_srdy !== 1'b0 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL rnd_empty: got srdy=%b pending=%0d expected 0/0", p_srdy, exp_q.size()); end
      $display("test_random: 400 cycles done");
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_write_read();
      test_mask();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
